// File: rtl/blowfish_iter_core.sv
// Iterative Blowfish core: one Feistel round per clock over run-time loaded P/S tables.
// Encrypt or decrypt is chosen per block; final whitening is folded into the last round.
module blowfish_iter_core #(
  parameter int ROUNDS = 16,
  parameter int CFG_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [63:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_data,
  output logic              busy
);

  localparam int CW = $clog2(ROUNDS + 1);
  localparam int PN = ROUNDS + 2;
  localparam int PW = $clog2(PN);
  localparam logic [CFG_AW-1:0] P_BASE  = CFG_AW'(1024);
  localparam logic [CFG_AW-1:0] P_END   = CFG_AW'(1024 + PN);
  localparam logic [PW-1:0]     P_IDX_R = PW'(ROUNDS);
  localparam logic [PW-1:0]     P_IDX_L = PW'(ROUNDS + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. in_ready/cfg_ready depend only on state; out_valid is held with out_data
  // stable until out_ready is seen, and the producer never withdraws it.
  assign in_ready  = (state_q == ST_IDLE);
  assign cfg_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  logic [31:0] sbox [1024];
  logic [31:0] parr [PN];

  logic          s_hit;
  logic          p_hit;
  logic [PW-1:0] p_waddr;

  assign s_hit   = (cfg_addr < P_BASE);
  assign p_hit   = (cfg_addr >= P_BASE) && (cfg_addr < P_END);
  assign p_waddr = PW'(cfg_addr - P_BASE);

  // Tables carry no reset; their content is owned by whoever loads them.
  always_ff @(posedge clk) begin
    if (cfg_we && cfg_ready) begin
      if (s_hit) sbox[cfg_addr[9:0]] <= cfg_wdata;
      if (p_hit) parr[p_waddr] <= cfg_wdata;
    end
  end

  logic [CW-1:0] cnt;
  logic          dec;
  logic [31:0]   l;
  logic [31:0]   r;

  logic [PW-1:0] p_rd;
  logic [31:0]   lx;
  logic [31:0]   fx;
  logic [31:0]   rx;
  logic [31:0]   wl;
  logic [31:0]   wr;
  logic          last_round;

  always_comb begin
    p_rd = dec ? PW'(ROUNDS + 1 - int'(cnt)) : PW'(cnt);
    lx   = l ^ parr[p_rd];
    fx   = ((sbox[{2'b00, lx[31:24]}] + sbox[{2'b01, lx[23:16]}])
            ^ sbox[{2'b10, lx[15:8]}]) + sbox[{2'b11, lx[7:0]}];
    rx   = r ^ fx;
    // Last round keeps L/R unswapped and applies the two whitening words.
    wl   = lx ^ parr[dec ? PW'(0) : P_IDX_L];
    wr   = rx ^ parr[dec ? PW'(1) : P_IDX_R];
    last_round = (cnt == CNT_LAST);
  end

  logic accept;
  logic step;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        step = 1'b1;
        if (last_round) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l        <= '0;
      r        <= '0;
      cnt      <= '0;
      dec      <= 1'b0;
      out_data <= '0;
    end else if (accept) begin
      l   <= in_data[63:32];
      r   <= in_data[31:0];
      dec <= in_decrypt;
      cnt <= '0;
    end else if (step) begin
      l   <= rx;
      r   <= lx;
      cnt <= cnt + CW'(1);
      if (last_round) out_data <= {wl, wr};
    end
  end

endmodule

// File: tb/tb_blowfish_iter_core.sv
// Directed bench for blowfish_iter_core: derives the standard pi tables, runs the
// Blowfish key schedule in a reference model and checks 16- and 4-round instances.
module tb_blowfish_iter_core;

  localparam int LIMIT = 200;
  localparam int NW    = 1046;

  logic clk = 1'b0;
  logic rst;

  // Index 0: ROUNDS=16 instance, index 1: ROUNDS=4 instance.
  logic        cfg_we     [2];
  logic [10:0] cfg_addr   [2];
  logic [31:0] cfg_wdata  [2];
  logic        cfg_ready  [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic        in_decrypt [2];
  logic [63:0] in_data    [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [63:0] out_data   [2];
  logic        busy       [2];

  blowfish_iter_core #(.ROUNDS(16), .CFG_AW(11)) u_dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0]), .cfg_wdata(cfg_wdata[0]), .cfg_ready(cfg_ready[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_decrypt(in_decrypt[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  blowfish_iter_core #(.ROUNDS(4), .CFG_AW(11)) u_dut4 (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1]), .cfg_wdata(cfg_wdata[1]), .cfg_ready(cfg_ready[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_decrypt(in_decrypt[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- pi digits (Machin formula, fixed point) ----------------
  logic [31:0] pw   [NW];
  logic [31:0] tm   [NW];
  logic [31:0] at   [NW];
  logic [31:0] a5   [NW];
  logic [31:0] pi_w [NW];

  // at = atan(1/x); word 0 is the integer part, words 1.. are fraction.
  task automatic calc_atan(input int unsigned x);
    longint unsigned rem, num, x1, x2, d, ti, ai, s, carry;
    int lz;
    x1 = x;
    x2 = x1 * x1;
    for (int i = 0; i < NW; i++) begin
      pw[i] = '0;
      tm[i] = '0;
    end
    pw[0] = 32'd1;
    rem = 0;
    for (int i = 0; i < NW; i++) begin
      num   = (rem << 32) | pw[i];
      pw[i] = 32'(num / x1);
      rem   = num % x1;
    end
    for (int i = 0; i < NW; i++) at[i] = pw[i];
    lz = 1;
    for (int k = 1; lz < NW; k++) begin
      rem = 0;
      for (int i = lz; i < NW; i++) begin
        num   = (rem << 32) | pw[i];
        pw[i] = 32'(num / x2);
        rem   = num % x2;
      end
      while (lz < NW && pw[lz] == 32'd0) lz++;
      d   = 64'(2 * k + 1);
      rem = 0;
      for (int i = lz; i < NW; i++) begin
        num   = (rem << 32) | pw[i];
        tm[i] = 32'(num / d);
        rem   = num % d;
      end
      carry = 0;
      for (int i = NW - 1; i >= 0 && (i >= lz || carry != 0); i--) begin
        ti = 0;
        if (i >= lz) ti = tm[i];
        ai = at[i];
        if (k % 2 == 1) begin
          s     = ai - ti - carry;
          carry = (ai < ti + carry) ? 64'd1 : 64'd0;
        end else begin
          s     = ai + ti + carry;
          carry = s >> 32;
        end
        at[i] = s[31:0];
      end
    end
  endtask

  // pi = 16*atan(1/5) - 4*atan(1/239)
  task automatic calc_pi();
    longint unsigned c1, c2, t1, t2;
    longint s;
    longint bw;
    calc_atan(5);
    for (int i = 0; i < NW; i++) a5[i] = at[i];
    calc_atan(239);
    c1 = 0;
    c2 = 0;
    bw = 0;
    for (int i = NW - 1; i >= 0; i--) begin
      t1 = a5[i];
      t1 = (t1 << 4) + c1;
      c1 = t1 >> 32;
      t2 = at[i];
      t2 = (t2 << 2) + c2;
      c2 = t2 >> 32;
      s  = longint'(t1 & 64'hFFFF_FFFF) - longint'(t2 & 64'hFFFF_FFFF) - bw;
      bw = (s < 0) ? 64'sd1 : 64'sd0;
      pi_w[i] = s[31:0];
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] pa [2][18];
  logic [31:0] sb [2][1024];

  function automatic logic [31:0] f_model(input int sm, input logic [31:0] x);
    logic [31:0] a;
    a = sb[sm][{2'd0, x[31:24]}] + sb[sm][{2'd1, x[23:16]}];
    a = a ^ sb[sm][{2'd2, x[15:8]}];
    return a + sb[sm][{2'd3, x[7:0]}];
  endfunction

  function automatic logic [63:0] bf_model(input int sm, input logic [63:0] blk, input logic dec);
    int nr;
    logic [31:0] l, r, t;
    nr = (sm == 1) ? 4 : 16;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < nr; i++) begin
      l = l ^ pa[sm][dec ? nr + 1 - i : i];
      r = r ^ f_model(sm, l);
      t = l; l = r; r = t;
    end
    t = l; l = r; r = t;
    r = r ^ pa[sm][dec ? 1 : nr];
    l = l ^ pa[sm][dec ? 0 : nr + 1];
    return {l, r};
  endfunction

  task automatic expand_key(input logic [63:0] key);
    logic [63:0] blk;
    for (int i = 0; i < 18; i++) pa[0][i] = pi_w[1 + i] ^ ((i % 2 == 0) ? key[63:32] : key[31:0]);
    for (int i = 0; i < 1024; i++) sb[0][i] = pi_w[19 + i];
    blk = '0;
    for (int i = 0; i < 18; i += 2) begin
      blk = bf_model(0, blk, 1'b0);
      pa[0][i] = blk[63:32];
      pa[0][i + 1] = blk[31:0];
    end
    for (int i = 0; i < 1024; i += 2) begin
      blk = bf_model(0, blk, 1'b0);
      sb[0][i] = blk[63:32];
      sb[0][i + 1] = blk[31:0];
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
  task automatic cfg_write(input int sm, input int addr, input logic [31:0] data);
    cfg_we[sm]    = 1'b1;
    cfg_addr[sm]  = 11'(addr);
    cfg_wdata[sm] = data;
    @(negedge clk);
    cfg_we[sm] = 1'b0;
  endtask

  task automatic load_tables(input int sm);
    int np;
    np = (sm == 1) ? 6 : 18;
    for (int i = 0; i < 1024; i++) cfg_write(sm, i, sb[sm][i]);
    for (int i = 0; i < np; i++) cfg_write(sm, 1024 + i, pa[sm][i]);
  endtask

  task automatic send(input int sm, input logic [63:0] d, input logic dec);
    int n;
    n = 0;
    while (!in_ready[sm] && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chkb("in_ready_wait", in_ready[sm], 1'b1);
    in_valid[sm]   = 1'b1;
    in_data[sm]    = d;
    in_decrypt[sm] = dec;
    @(negedge clk);
    // Mode and data change after acceptance must not affect the block in flight.
    in_valid[sm]   = 1'b0;
    in_data[sm]    = ~d;
    in_decrypt[sm] = ~dec;
  endtask

  task automatic wait_out(input int sm, output int lat);
    lat = 0;
    while (!out_valid[sm] && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input int sm, input logic [63:0] d, input logic dec,
                     output logic [63:0] res, output int lat);
    out_ready[sm] = 1'b1;
    send(sm, d, dec);
    wait_out(sm, lat);
    res = out_data[sm];
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] res, res2, exp, blk, held;
    int lat, stall;
    logic dec;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cfg_we[s] = 1'b0; cfg_addr[s] = '0; cfg_wdata[s] = '0;
      in_valid[s] = 1'b0; in_decrypt[s] = 1'b0; in_data[s] = '0;
      out_ready[s] = 1'b1;
    end
    calc_pi();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chkb("rst_out_valid", out_valid[0], 1'b0);
    chk ("rst_out_data", out_data[0], 64'h0);
    chkb("rst_in_ready", in_ready[0], 1'b1);
    chkb("rst_cfg_ready", cfg_ready[0], 1'b1);
    chkb("rst_busy", busy[0], 1'b0);
    chk ("rst_out_data4", out_data[1], 64'h0);

    // Key 0, plaintext 0
    expand_key(64'h0);
    load_tables(0);
    run(0, 64'h0, 1'b0, res, lat);
    chk ("k0_enc", res, 64'h4EF997456198DD78);
    chki("k0_latency", lat, 16);

    // Key all-ones, encrypt then decrypt
    expand_key(64'hFFFF_FFFF_FFFF_FFFF);
    load_tables(0);
    run(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, res, lat);
    chk ("kf_enc", res, 64'h51866FD5B85ECB8A);
    run(0, 64'h51866FD5B85ECB8A, 1'b1, res, lat);
    chk ("kf_dec", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chki("kf_dec_latency", lat, 16);

    // Back-pressure: hold out_ready low 10 cycles, config writes must be dropped
    blk = 64'h0123_4567_89AB_CDEF;
    exp = bf_model(0, blk, 1'b0);
    out_ready[0] = 1'b0;
    send(0, blk, 1'b0);
    wait_out(0, lat);
    chki("hold_latency", lat, 16);
    held = out_data[0];
    chk ("hold_first", held, exp);
    for (int i = 0; i < 10; i++) begin
      cfg_we[0]    = 1'b1;
      cfg_addr[0]  = 11'(1024 + i);
      cfg_wdata[0] = $urandom;
      @(negedge clk);
      chk ("hold_data", out_data[0], exp);
      chkb("hold_valid", out_valid[0], 1'b1);
      chkb("hold_in_ready", in_ready[0], 1'b0);
      chkb("hold_cfg_ready", cfg_ready[0], 1'b0);
    end
    cfg_we[0]    = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chkb("release_valid", out_valid[0], 1'b0);
    chkb("release_in_ready", in_ready[0], 1'b1);

    // Out-of-range addresses are ignored; readback shows tables intact
    cfg_write(0, 1042, $urandom);
    cfg_write(0, 2047, $urandom);
    run(0, blk, 1'b0, res, lat);
    chk ("readback_enc", res, exp);

    // Config write and acceptance in the same IDLE cycle: new P[0] is used
    pa[0][0] = 32'hA5A5_5A5A;
    blk = 64'hFEDC_BA98_7654_3210;
    exp = bf_model(0, blk, 1'b0);
    cfg_we[0] = 1'b1; cfg_addr[0] = 11'd1024; cfg_wdata[0] = 32'hA5A5_5A5A;
    in_valid[0] = 1'b1; in_data[0] = blk; in_decrypt[0] = 1'b0;
    @(negedge clk);
    cfg_we[0] = 1'b0; in_valid[0] = 1'b0;
    wait_out(0, lat);
    chk ("same_cycle_enc", out_data[0], exp);
    chki("same_cycle_latency", lat, 16);
    @(negedge clk);

    // Reset mid-ROUND; a write during ROUND is dropped too
    blk = 64'h0000_0000_FFFF_FFFF;
    send(0, blk, 1'b0);
    cfg_write(0, 1027, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    chkb("pre_rst_busy", busy[0], 1'b1);
    rst = 1'b1;
    #1;
    chkb("mid_rst_out_valid", out_valid[0], 1'b0);
    chk ("mid_rst_out_data", out_data[0], 64'h0);
    chkb("mid_rst_busy", busy[0], 1'b0);
    chkb("mid_rst_in_ready", in_ready[0], 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(0, blk, 1'b0, res, lat);
    chk ("post_rst_enc", res, bf_model(0, blk, 1'b0));

    // Stream of random blocks, mixed modes, random output stalls
    for (int n = 0; n < 100; n++) begin
      blk   = {$urandom, $urandom};
      dec   = 1'($urandom_range(0, 1));
      stall = int'($urandom_range(0, 3));
      exp_q.push_back(bf_model(0, blk, dec));
      out_ready[0] = (stall == 0);
      send(0, blk, dec);
      wait_out(0, lat);
      chki("stream_latency", lat, 16);
      repeat (stall) @(negedge clk);
      chk ("stream_data", out_data[0], exp_q.pop_front());
      out_ready[0] = 1'b1;
      @(negedge clk);
      chkb("stream_no_dup", out_valid[0], 1'b0);
    end

    // ROUNDS=4 instance with random tables
    for (int i = 0; i < 6; i++) pa[1][i] = $urandom;
    for (int i = 0; i < 1024; i++) sb[1][i] = $urandom;
    load_tables(1);
    for (int n = 0; n < 3; n++) begin
      blk = (n == 0) ? 64'h0 : (n == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      run(1, blk, 1'b0, res, lat);
      chk ("r4_enc", res, bf_model(1, blk, 1'b0));
      chki("r4_latency", lat, 4);
      run(1, res, 1'b1, res2, lat);
      chk ("r4_dec", res2, blk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
